// File: rtl/alu_pipe_l7.sv
// Pipelined integer ALU: S0 computes, later stages carry the result, and a
// bubble-compressing valid/ready chain presents it on the writeback side.
package alu_pipe_l7_pkg;
   typedef logic [3:0] rv_uop_t;
   localparam rv_uop_t OP_ADD   = 4'd0;
   localparam rv_uop_t OP_SUB   = 4'd1;
   localparam rv_uop_t OP_AND   = 4'd2;
   localparam rv_uop_t OP_OR    = 4'd3;
   localparam rv_uop_t OP_XOR   = 4'd4;
   localparam rv_uop_t OP_SLT   = 4'd5;
   localparam rv_uop_t OP_SLTU  = 4'd6;
   localparam rv_uop_t OP_SRA   = 4'd7;
   localparam rv_uop_t OP_SRL   = 4'd8;
   localparam rv_uop_t OP_SLL   = 4'd9;
   localparam rv_uop_t OP_LUI   = 4'd10;
   localparam rv_uop_t OP_AUIPC = 4'd11;
   localparam rv_uop_t OP_MUL   = 4'd12;
endpackage

module alu_pipe_l7
   import alu_pipe_l7_pkg::*;
#(
   parameter int unsigned p_seq_num_bits   = 5,
   parameter int unsigned p_phys_addr_bits = 6,
   parameter int unsigned p_num_stages     = 2,
   parameter bit          p_en_mul         = 1'b0
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                d_val,
   input  logic [31:0]                         d_pc,
   input  logic [p_seq_num_bits-1:0]           d_seq_num,
   input  logic [31:0]                         d_op1,
   input  logic [31:0]                         d_op2,
   input  logic [4:0]                          d_waddr,
   input  rv_uop_t                             d_uop,
   input  logic [p_phys_addr_bits-1:0]         d_preg,
   input  logic [p_phys_addr_bits-1:0]         d_ppreg,
   output logic                                d_rdy,
   output logic                                w_val,
   output logic [31:0]                         w_pc,
   output logic [p_seq_num_bits-1:0]           w_seq_num,
   output logic [4:0]                          w_waddr,
   output logic [31:0]                         w_wdata,
   output logic                                w_wen,
   output logic [p_phys_addr_bits-1:0]         w_preg,
   output logic [p_phys_addr_bits-1:0]         w_ppreg,
   input  logic                                w_rdy,
   input  logic                                flush,
   output logic [$clog2(p_num_stages+1)-1:0]   occupancy,
   output logic                                busy
);
   localparam int unsigned N     = p_num_stages;
   localparam int unsigned OCC_W = $clog2(N + 1);
   localparam int unsigned SB    = p_seq_num_bits;
   localparam int unsigned PB    = p_phys_addr_bits;

   logic [N-1:0]    vld, vld_nxt, adv;
   logic            accept;
   logic [OCC_W-1:0] occ_nxt;
   logic [31:0]     s_pc [N];
   logic [31:0]     s_op1 [N];
   logic [31:0]     s_op2 [N];
   logic [SB-1:0]   s_seq [N];
   logic [4:0]      s_waddr [N];
   rv_uop_t         s_uop [N];
   logic [PB-1:0]   s_preg [N];
   logic [PB-1:0]   s_ppreg [N];
   logic [31:0]     alu_res, mul_lo, a, b;

   // Advance chain runs from the output back: a stage moves when the next one is free or moving.
   always_comb begin
      adv      = '0;
      vld_nxt  = '0;
      w_val    = vld[N-1] & ~flush;
      adv[N-1] = w_val & w_rdy;
      for (int i = int'(N) - 2; i >= 0; i--) begin
         adv[i] = vld[i] & (~vld[i+1] | adv[i+1]);
      end
      d_rdy  = ~flush & (~vld[0] | adv[0]);
      accept = d_val & d_rdy;
      if (!flush) begin
         for (int i = 0; i < int'(N); i++) vld_nxt[i] = vld[i] & ~adv[i];
         vld_nxt[0] = vld_nxt[0] | accept;
         for (int i = 1; i < int'(N); i++) vld_nxt[i] = vld_nxt[i] | adv[i-1];
      end
   end

   always_comb begin
      occ_nxt = '0;
      for (int i = 0; i < int'(N); i++) occ_nxt = occ_nxt + OCC_W'(vld_nxt[i]);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld       <= '0;
         occupancy <= '0;
         busy      <= 1'b0;
      end else begin
         vld       <= vld_nxt;
         occupancy <= occ_nxt;
         busy      <= |vld_nxt;
      end
   end

   // Payload carries no reset; it is only meaningful alongside its valid bit.
   always_ff @(posedge clk) begin
      if (accept) begin
         s_pc[0]    <= d_pc;
         s_op1[0]   <= d_op1;
         s_op2[0]   <= d_op2;
         s_seq[0]   <= d_seq_num;
         s_waddr[0] <= d_waddr;
         s_uop[0]   <= d_uop;
         s_preg[0]  <= d_preg;
         s_ppreg[0] <= d_ppreg;
      end
      for (int i = 1; i < int'(N); i++) begin
         if (adv[i-1]) begin
            s_pc[i]    <= s_pc[i-1];
            s_op1[i]   <= s_op1[i-1];
            s_op2[i]   <= s_op2[i-1];
            s_seq[i]   <= s_seq[i-1];
            s_waddr[i] <= s_waddr[i-1];
            s_uop[i]   <= s_uop[i-1];
            s_preg[i]  <= s_preg[i-1];
            s_ppreg[i] <= s_ppreg[i-1];
         end
      end
   end

   assign a = s_op1[0];
   assign b = s_op2[0];

   if (p_en_mul) begin : g_mul
      assign mul_lo = a * b;
   end else begin : g_no_mul
      assign mul_lo = '0;
   end

   always_comb begin
      alu_res = '0;
      case (s_uop[0])
         OP_ADD:   alu_res = a + b;
         OP_SUB:   alu_res = a - b;
         OP_AND:   alu_res = a & b;
         OP_OR:    alu_res = a | b;
         OP_XOR:   alu_res = a ^ b;
         OP_SLT:   alu_res = {31'd0, $signed(a) < $signed(b)};
         OP_SLTU:  alu_res = {31'd0, a < b};
         OP_SRA:   alu_res = 32'($signed(a) >>> b[4:0]);
         OP_SRL:   alu_res = a >> b[4:0];
         OP_SLL:   alu_res = a << b[4:0];
         OP_LUI:   alu_res = b;
         OP_AUIPC: alu_res = s_pc[0] + b;
         OP_MUL:   alu_res = mul_lo;
         default:  alu_res = '0;
      endcase
   end

   // Single stage writes back straight from the ALU; deeper pipes register it into S1.
   if (N == 1) begin : g_comb_wb
      assign w_wdata = alu_res;
   end else begin : g_reg_wb
      logic [31:0] s_res [N-1:1];
      always_ff @(posedge clk) begin
         if (adv[0]) s_res[1] <= alu_res;
         for (int i = 2; i < int'(N); i++) begin
            if (adv[i-1]) s_res[i] <= s_res[i-1];
         end
      end
      assign w_wdata = s_res[N-1];
   end

   assign w_pc      = s_pc[N-1];
   assign w_seq_num = s_seq[N-1];
   assign w_waddr   = s_waddr[N-1];
   assign w_preg    = s_preg[N-1];
   assign w_ppreg   = s_ppreg[N-1];
   assign w_wen     = 1'b1;
endmodule

// File: tb/tb_alu_pipe_l7.sv
// Bench for alu_pipe_l7: four instances (N=2, N=3+mul, N=1+mul, N=1) with
// vector tables, directed corner sequences and a queue-based random model.
`timescale 1ns/1ps
module tb_alu_pipe_l7;
   import alu_pipe_l7_pkg::*;
   localparam int unsigned SB = 5;
   localparam int unsigned PB = 6;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic          dv [4];
   logic [31:0]   pc, op1, op2;
   logic [SB-1:0] seq;
   logic [4:0]    waddr;
   rv_uop_t       uop;
   logic [PB-1:0] preg, ppreg;
   logic          flush, w_rdy;

   logic          d_rdy_v [4];
   logic          w_val_v [4];
   logic          w_wen_v [4];
   logic          busy_v [4];
   logic [31:0]   w_pc_v [4];
   logic [31:0]   w_wdata_v [4];
   logic [SB-1:0] w_seq_v [4];
   logic [4:0]    w_waddr_v [4];
   logic [PB-1:0] w_preg_v [4];
   logic [PB-1:0] w_ppreg_v [4];
   logic [3:0]    occ_v [4];

   int checks = 0;
   int errors = 0;

   for (genvar k = 0; k < 4; k++) begin : g_dut
      localparam int unsigned NK = (k == 0) ? 2 : ((k == 1) ? 3 : 1);
      logic [$clog2(NK+1)-1:0] occ;
      alu_pipe_l7 #(
         .p_seq_num_bits(SB), .p_phys_addr_bits(PB),
         .p_num_stages(NK), .p_en_mul(1'((k == 1) || (k == 2)))
      ) u_dut (
         .clk(clk), .rst(rst),
         .d_val(dv[k]), .d_pc(pc), .d_seq_num(seq), .d_op1(op1), .d_op2(op2),
         .d_waddr(waddr), .d_uop(uop), .d_preg(preg), .d_ppreg(ppreg), .d_rdy(d_rdy_v[k]),
         .w_val(w_val_v[k]), .w_pc(w_pc_v[k]), .w_seq_num(w_seq_v[k]), .w_waddr(w_waddr_v[k]),
         .w_wdata(w_wdata_v[k]), .w_wen(w_wen_v[k]), .w_preg(w_preg_v[k]), .w_ppreg(w_ppreg_v[k]),
         .w_rdy(w_rdy), .flush(flush), .occupancy(occ), .busy(busy_v[k])
      );
      assign occ_v[k] = 4'(occ);
   end

   function automatic int n_of(input int k);
      return (k == 0) ? 2 : ((k == 1) ? 3 : 1);
   endfunction

   // Reference ALU from the instruction rules, independent of the RTL's expressions.
   function automatic logic [31:0] alu_ref(input rv_uop_t u, input logic [31:0] x, input logic [31:0] y,
                                           input logic [31:0] p, input bit mul);
      logic [4:0] sh;
      logic [63:0] prod;
      sh = y[4:0];
      prod = 64'(x) * 64'(y);
      case (u)
         OP_ADD:   return x + y;
         OP_SUB:   return x - y;
         OP_AND:   return x & y;
         OP_OR:    return x | y;
         OP_XOR:   return x ^ y;
         OP_SLT:   return ((x ^ 32'h8000_0000) < (y ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
         OP_SLTU:  return (x < y) ? 32'd1 : 32'd0;
         OP_SRL:   return x >> sh;
         OP_SRA:   return (x >> sh) | (x[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
         OP_SLL:   return x << sh;
         OP_LUI:   return y;
         OP_AUIPC: return p + y;
         OP_MUL:   return mul ? 32'(prod) : 32'd0;
         default:  return 32'd0;
      endcase
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_op(input rv_uop_t u, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] p, input int s);
      uop = u; op1 = x; op2 = y; pc = p;
      seq = SB'(s); waddr = 5'(s + 3); preg = PB'(s + 1); ppreg = PB'(s + 2);
   endtask

   function automatic logic [63:0] out_tag(input int k);
      return {10'd0, w_seq_v[k], w_waddr_v[k], w_preg_v[k], w_ppreg_v[k], w_pc_v[k]};
   endfunction

   typedef struct packed { logic [31:0] data; logic [63:0] tag; } exp_t;

   task automatic run_random(input int k, input int cycles);
      exp_t q[$];
      exp_t e, h;
      int nn;
      bit acc, xf, mulk;
      nn = n_of(k);
      mulk = (k == 1) || (k == 2);
      @(negedge clk);
      dv = '{default: 1'b0}; flush = 1'b1; w_rdy = 1'b0;
      @(negedge clk);
      flush = 1'b0;
      for (int c = 0; c < cycles; c++) begin
         chk("rnd_occ", 64'(occ_v[k]), 64'(q.size()));
         chk("rnd_busy", 64'(busy_v[k]), 64'(q.size() != 0));
         flush = ($urandom_range(0, 24) == 0);
         w_rdy = ($urandom_range(0, 3) != 0);
         dv[k] = ($urandom_range(0, 3) != 0);
         set_op(rv_uop_t'($urandom_range(0, 15)), $urandom, $urandom, $urandom, c);
         e.data = alu_ref(uop, op1, op2, pc, mulk);
         e.tag  = {10'd0, seq, waddr, preg, ppreg, pc};
         #1;
         chk("rnd_rdy", 64'(d_rdy_v[k]), 64'(!flush && (q.size() < nn || w_rdy)));
         if (flush || q.size() == 0) chk("rnd_wval_idle", 64'(w_val_v[k]), 64'd0);
         xf = w_val_v[k] && w_rdy;
         if (xf && q.size() > 0) begin
            h = q.pop_front();
            chk("rnd_wdata", 64'(w_wdata_v[k]), 64'(h.data));
            chk("rnd_tag", out_tag(k), h.tag);
         end
         acc = dv[k] && d_rdy_v[k];
         if (flush) q.delete();
         else if (acc) q.push_back(e);
         @(negedge clk);
      end
      dv[k] = 1'b0; flush = 1'b0; w_rdy = 1'b1;
      for (int c = 0; c < 4 * nn + 4 && q.size() > 0; c++) begin
         #1;
         if (w_val_v[k]) begin
            h = q.pop_front();
            chk("rnd_drain_wdata", 64'(w_wdata_v[k]), 64'(h.data));
            chk("rnd_drain_tag", out_tag(k), h.tag);
         end
         @(negedge clk);
      end
      chk("rnd_drain_empty", 64'(q.size()), 64'd0);
   endtask

   typedef struct {
      rv_uop_t     uop;
      logic [31:0] op1, op2, pc, exp;
      bit          is_mul;
   } vec_t;
   localparam int NV = 19;
   vec_t tv [NV];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen, got;
      bit acc;
      logic [31:0] exp30 [3];
      tv[0]  = '{OP_ADD,   32'hFFFF_FFFF, 32'd1,         32'd0,         32'd0,         1'b0};
      tv[1]  = '{OP_SUB,   32'd0,         32'd1,         32'd0,         32'hFFFF_FFFF, 1'b0};
      tv[2]  = '{OP_AND,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0,         32'hF000_F000, 1'b0};
      tv[3]  = '{OP_OR,    32'hF0F0_F0F0, 32'h0F0F_0000, 32'd0,         32'hFFFF_F0F0, 1'b0};
      tv[4]  = '{OP_XOR,   32'hAAAA_5555, 32'hFFFF_0000, 32'd0,         32'h5555_5555, 1'b0};
      tv[5]  = '{OP_SLT,   32'hFFFF_FFFF, 32'd1,         32'd0,         32'd1,         1'b0};
      tv[6]  = '{OP_SLT,   32'd5,         32'h8000_0000, 32'd0,         32'd0,         1'b0};
      tv[7]  = '{OP_SLTU,  32'hFFFF_FFFF, 32'd1,         32'd0,         32'd0,         1'b0};
      tv[8]  = '{OP_SRA,   32'h7FFF_FFF0, 32'd4,         32'd0,         32'h07FF_FFFF, 1'b0};
      tv[9]  = '{OP_SRA,   32'h8000_0001, 32'h3F,        32'd0,         32'hFFFF_FFFF, 1'b0};
      tv[10] = '{OP_SRL,   32'h8000_0000, 32'h21,        32'd0,         32'h4000_0000, 1'b0};
      tv[11] = '{OP_SLL,   32'd1,         32'h1F,        32'd0,         32'h8000_0000, 1'b0};
      tv[12] = '{OP_LUI,   32'h1234,      32'hABCD_E000, 32'd0,         32'hABCD_E000, 1'b0};
      tv[13] = '{OP_AUIPC, 32'd0,         32'h2000,      32'hFFFF_F000, 32'h0000_1000, 1'b0};
      tv[14] = '{OP_MUL,   32'h1_0000,    32'h1_0000,    32'd0,         32'd0,         1'b1};
      tv[15] = '{OP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1,         1'b1};
      tv[16] = '{OP_MUL,   32'd3,         32'd5,         32'd0,         32'd15,        1'b1};
      tv[17] = '{rv_uop_t'(13), 32'd5,    32'd5,         32'd0,         32'd0,         1'b0};
      tv[18] = '{rv_uop_t'(15), 32'd7,    32'd9,         32'd0,         32'd0,         1'b0};

      dv = '{default: 1'b0}; flush = 1'b0; w_rdy = 1'b1;
      set_op(OP_ADD, 32'd0, 32'd0, 32'd0, 0);
      #3;
      for (int k = 0; k < 4; k++) begin
         chk("rst_wval", 64'(w_val_v[k]), 64'd0);
         chk("rst_busy", 64'(busy_v[k]), 64'd0);
         chk("rst_occ", 64'(occ_v[k]), 64'd0);
         chk("rst_rdy", 64'(d_rdy_v[k]), 64'd1);
      end
      @(negedge clk);
      rst = 1'b1;

      // Vector table on the single-stage instances, with and without the multiplier.
      for (int k = 2; k < 4; k++) begin
         for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            set_op(tv[i].uop, tv[i].op1, tv[i].op2, tv[i].pc, i);
            dv[k] = 1'b1;
            #1 chk($sformatf("tbl_rdy_k%0d_%0d", k, i), 64'(d_rdy_v[k]), 64'd1);
            @(negedge clk);
            dv[k] = 1'b0;
            #1;
            chk($sformatf("tbl_val_k%0d_%0d", k, i), 64'(w_val_v[k]), 64'd1);
            chk($sformatf("tbl_data_k%0d_%0d", k, i), 64'(w_wdata_v[k]),
                64'((k == 3 && tv[i].is_mul) ? 32'd0 : tv[i].exp));
            chk($sformatf("tbl_wen_k%0d_%0d", k, i), 64'(w_wen_v[k]), 64'd1);
         end
      end

      // N=2: ADD 5+7 shows up exactly one cycle later than accept+1, then goes away.
      @(negedge clk);
      set_op(OP_ADD, 32'd5, 32'd7, 32'h40, 1);
      dv[0] = 1'b1;
      #1 chk("t29_rdy", 64'(d_rdy_v[0]), 64'd1);
      @(negedge clk); dv[0] = 1'b0;
      #1 chk("t29_c1_val", 64'(w_val_v[0]), 64'd0);
      @(negedge clk);
      #1;
      chk("t29_c2_val", 64'(w_val_v[0]), 64'd1);
      chk("t29_c2_data", 64'(w_wdata_v[0]), 64'd12);
      chk("t29_c2_seq", 64'(w_seq_v[0]), 64'd1);
      @(negedge clk);
      #1 chk("t29_c3_val", 64'(w_val_v[0]), 64'd0);

      // N=3: three back-to-back ops stream out on consecutive cycles.
      exp30[0] = 32'hFFFF_FFFE; exp30[1] = 32'hF800_0000; exp30[2] = 32'd1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         case (i)
            0: set_op(OP_SUB, 32'd3, 32'd5, 32'd0, 2);
            1: set_op(OP_SRA, 32'h8000_0000, 32'd4, 32'd0, 3);
            default: set_op(OP_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd0, 4);
         endcase
         dv[1] = 1'b1;
         #1 chk($sformatf("t30_rdy_%0d", i), 64'(d_rdy_v[1]), 64'd1);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); dv[1] = 1'b0;
         #1;
         chk($sformatf("t30_val_%0d", i), 64'(w_val_v[1]), 64'd1);
         chk($sformatf("t30_data_%0d", i), 64'(w_wdata_v[1]), 64'(exp30[i]));
      end
      @(negedge clk);
      #1 chk("t30_after_val", 64'(w_val_v[1]), 64'd0);

      // N=2 back-pressure: third op must wait, then all three leave in order.
      @(negedge clk);
      w_rdy = 1'b0; set_op(OP_ADD, 32'd1, 32'd0, 32'd0, 1); dv[0] = 1'b1;
      #1 chk("t31_rdy_a", 64'(d_rdy_v[0]), 64'd1);
      @(negedge clk);
      set_op(OP_ADD, 32'd2, 32'd0, 32'd0, 2);
      #1 chk("t31_rdy_b", 64'(d_rdy_v[0]), 64'd1);
      @(negedge clk);
      set_op(OP_ADD, 32'd3, 32'd0, 32'd0, 3);
      #1;
      chk("t31_rdy_c", 64'(d_rdy_v[0]), 64'd0);
      chk("t31_occ", 64'(occ_v[0]), 64'd2);
      chk("t31_wval_held", 64'(w_val_v[0]), 64'd1);
      @(negedge clk);
      #1;
      chk("t31_rdy_c2", 64'(d_rdy_v[0]), 64'd0);
      chk("t31_held_seq", 64'(w_seq_v[0]), 64'd1);
      @(negedge clk);
      w_rdy = 1'b1; got = 0;
      for (int c = 0; c < 10 && got < 3; c++) begin
         #1;
         if (w_val_v[0]) begin
            chk($sformatf("t31_order_%0d", got), 64'(w_seq_v[0]), 64'(got + 1));
            chk($sformatf("t31_data_%0d", got), 64'(w_wdata_v[0]), 64'(got + 1));
            got++;
         end
         acc = dv[0] && d_rdy_v[0];
         @(negedge clk);
         if (acc) dv[0] = 1'b0;
      end
      chk("t31_count", 64'(got), 64'd3);
      dv[0] = 1'b0;

      // N=3 flush of a full pipe with an op offered in the same cycle.
      @(negedge clk);
      w_rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_op(OP_ADD, 32'(i), 32'd100, 32'd0, 10 + i);
         dv[1] = 1'b1;
         @(negedge clk);
      end
      #1 chk("t32_full_occ", 64'(occ_v[1]), 64'd3);
      set_op(OP_ADD, 32'd9, 32'd9, 32'd0, 13);
      flush = 1'b1;
      #1;
      chk("t32_rdy", 64'(d_rdy_v[1]), 64'd0);
      chk("t32_wval", 64'(w_val_v[1]), 64'd0);
      @(negedge clk);
      flush = 1'b0; dv[1] = 1'b0;
      #1;
      chk("t32_occ", 64'(occ_v[1]), 64'd0);
      chk("t32_busy", 64'(busy_v[1]), 64'd0);
      w_rdy = 1'b1; seen = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         #1 if (w_val_v[1]) seen++;
      end
      chk("t32_none", 64'(seen), 64'd0);

      // N=3 asynchronous reset mid-stream, then a fresh AUIPC.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         set_op(OP_ADD, 32'(i), 32'd1, 32'd0, 20 + i);
         dv[1] = 1'b1;
      end
      @(negedge clk);
      #1;
      chk("t33_busy_pre", 64'(busy_v[1]), 64'd1);
      chk("t33_wval_pre", 64'(w_val_v[1]), 64'd1);
      #1 rst = 1'b0;
      #1;
      chk("t33_wval_rst", 64'(w_val_v[1]), 64'd0);
      chk("t33_busy_rst", 64'(busy_v[1]), 64'd0);
      chk("t33_occ_rst", 64'(occ_v[1]), 64'd0);
      dv[1] = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      set_op(OP_AUIPC, 32'd0, 32'h1000, 32'h100, 30);
      dv[1] = 1'b1; seen = 0;
      for (int c = 0; c < 8; c++) begin
         #1;
         if (w_val_v[1]) begin
            seen++;
            chk("t33_data", 64'(w_wdata_v[1]), 64'h1100);
            chk("t33_seq", 64'(w_seq_v[1]), 64'd30);
         end
         @(negedge clk);
         dv[1] = 1'b0;
      end
      chk("t33_count", 64'(seen), 64'd1);

      run_random(1, 400);
      run_random(0, 400);
      run_random(2, 200);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
